// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: state encodings,
// access size codes, IO address select and bus/instruction widths.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef logic [ADDR_W-1:0] ADDR_TYPE;
    typedef logic [INST_W-1:0] INST_TYPE;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_IF_READ   = 2'd1,
        ST_LSB_READ  = 2'd2,
        ST_LSB_WRITE = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int         IO_SEL_HI  = 17;
    localparam int         IO_SEL_LO  = 16;
    localparam logic [1:0] IO_SEL_VAL = 2'b11;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic is_io_sel(input logic [1:0] sel);
        return sel == IO_SEL_VAL;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO port controller serving instruction fetch and the load/store buffer.
// Optional: define MEM_CTRL_IO_STALL_EN to hold IO stores while the UART buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        io_buffer_full,
    input  logic        if_start_signal,
    input  ADDR_TYPE    if_query_pc,
    output logic        if_finish_signal,
    output INST_TYPE    if_inst,
    input  logic        lsb_start_signal,
    input  logic        lsb_wr,
    input  ADDR_TYPE    lsb_addr,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_finish_signal,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output ADDR_TYPE    mem_a,
    output logic        mem_wr
);

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  nbytes_q;
    ADDR_TYPE    addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;

    logic        if_pending_q;
    logic        lsb_pending_q;
    ADDR_TYPE    if_pc_q;
    ADDR_TYPE    lsb_addr_q;
    logic        lsb_wr_q;
    logic [1:0]  lsb_size_q;
    logic [31:0] lsb_wdata_q;

    logic        if_finish_q;
    logic        lsb_finish_q;
    logic        mem_wr_q;
    ADDR_TYPE    mem_a_q;
    logic [7:0]  mem_dout_q;
    INST_TYPE    if_inst_q;
    logic [31:0] lsb_rdata_q;

    logic        if_req;
    logic        lsb_req;
    logic        io_block;
    ADDR_TYPE    if_pc_eff;
    ADDR_TYPE    lsb_addr_eff;
    logic        lsb_wr_eff;
    logic [1:0]  lsb_size_eff;
    logic [31:0] lsb_wdata_eff;
    logic [2:0]  cnt_nxt;
    logic [1:0]  rd_idx;
    logic [31:0] data_d;
    ADDR_TYPE    addr_nxt;
    logic [7:0]  wbyte_nxt;

    // A pulse arriving this cycle is visible alongside the latched request so
    // IDLE can dispatch it at the same edge that would latch it.
    always_comb begin
        if_req        = !rollback && (if_start_signal || if_pending_q);
        lsb_req       = !rollback && (lsb_start_signal || lsb_pending_q);
        if_pc_eff     = if_start_signal  ? if_query_pc : if_pc_q;
        lsb_addr_eff  = lsb_start_signal ? lsb_addr    : lsb_addr_q;
        lsb_wr_eff    = lsb_start_signal ? lsb_wr      : lsb_wr_q;
        lsb_size_eff  = lsb_start_signal ? lsb_size    : lsb_size_q;
        lsb_wdata_eff = lsb_start_signal ? lsb_wdata   : lsb_wdata_q;

        cnt_nxt   = cnt_q + 3'd1;
        rd_idx    = cnt_q[1:0] - 2'd1;
        data_d    = data_q;
        data_d[{rd_idx, 3'b000} +: 8] = mem_din;
        addr_nxt  = addr_q + ADDR_TYPE'(cnt_nxt);
        wbyte_nxt = wdata_q[{cnt_nxt[1:0], 3'b000} +: 8];
    end

`ifdef MEM_CTRL_IO_STALL_EN
    assign io_block = lsb_wr_eff && io_buffer_full
                      && is_io_sel(lsb_addr_eff[IO_SEL_HI:IO_SEL_LO]);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_block       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            nbytes_q      <= 3'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            data_q        <= '0;
            if_pending_q  <= 1'b0;
            lsb_pending_q <= 1'b0;
            if_pc_q       <= '0;
            lsb_addr_q    <= '0;
            lsb_wr_q      <= 1'b0;
            lsb_size_q    <= SIZE_BYTE;
            lsb_wdata_q   <= '0;
            if_finish_q   <= 1'b0;
            lsb_finish_q  <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            if_inst_q     <= '0;
            lsb_rdata_q   <= '0;
        end else if (rdy) begin
            if_finish_q  <= 1'b0;
            lsb_finish_q <= 1'b0;

            if (rollback) begin
                if_pending_q  <= 1'b0;
                lsb_pending_q <= 1'b0;
            end else begin
                if (if_start_signal) begin
                    if_pending_q <= 1'b1;
                    if_pc_q      <= if_query_pc;
                end
                if (lsb_start_signal) begin
                    lsb_pending_q <= 1'b1;
                    lsb_addr_q    <= lsb_addr;
                    lsb_wr_q      <= lsb_wr;
                    lsb_size_q    <= lsb_size;
                    lsb_wdata_q   <= lsb_wdata;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    // A blocked IO store still holds off fetches to keep LSB priority.
                    if (lsb_req && !io_block) begin
                        lsb_pending_q <= 1'b0;
                        state_q       <= lsb_wr_eff ? ST_LSB_WRITE : ST_LSB_READ;
                        addr_q        <= lsb_addr_eff;
                        nbytes_q      <= size_bytes(lsb_size_eff);
                        wdata_q       <= lsb_wdata_eff;
                        cnt_q         <= 3'd0;
                        data_q        <= '0;
                        mem_a_q       <= lsb_addr_eff;
                        mem_wr_q      <= lsb_wr_eff;
                        mem_dout_q    <= lsb_wr_eff ? lsb_wdata_eff[7:0] : 8'h00;
                    end else if (if_req && !lsb_req) begin
                        if_pending_q <= 1'b0;
                        state_q      <= ST_IF_READ;
                        addr_q       <= if_pc_eff;
                        nbytes_q     <= 3'd4;
                        cnt_q        <= 3'd0;
                        data_q       <= '0;
                        mem_a_q      <= if_pc_eff;
                        mem_wr_q     <= 1'b0;
                    end
                end
                ST_IF_READ, ST_LSB_READ: begin
                    if (rollback) begin
                        state_q <= ST_IDLE;
                    end else begin
                        // cnt_q counts issued addresses; mem_din carries byte cnt_q-1.
                        cnt_q <= cnt_nxt;
                        if (cnt_q != 3'd0) data_q <= data_d;
                        if (cnt_nxt < nbytes_q) mem_a_q <= addr_nxt;
                        if (cnt_q == nbytes_q) begin
                            state_q <= ST_IDLE;
                            if (state_q == ST_IF_READ) begin
                                if_finish_q <= 1'b1;
                                if_inst_q   <= data_d;
                            end else begin
                                lsb_finish_q <= 1'b1;
                                lsb_rdata_q  <= data_d;
                            end
                        end
                    end
                end
                ST_LSB_WRITE: begin
                    if (cnt_nxt < nbytes_q) begin
                        cnt_q      <= cnt_nxt;
                        mem_a_q    <= addr_nxt;
                        mem_dout_q <= wbyte_nxt;
                    end else begin
                        mem_wr_q     <= 1'b0;
                        lsb_finish_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign if_finish_signal  = if_finish_q;
    assign if_inst           = if_inst_q;
    assign lsb_finish_signal = lsb_finish_q;
    assign lsb_rdata         = lsb_rdata_q;
    assign mem_a             = mem_a_q;
    assign mem_dout          = mem_dout_q;
    assign mem_wr            = mem_wr_q & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized requests, checked
// against a transaction-level model of the byte-serial port.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback, io_buffer_full;
    logic        if_start_signal, if_finish_signal;
    logic [31:0] if_query_pc, if_inst;
    logic        lsb_start_signal, lsb_wr, lsb_finish_signal;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_size;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .io_buffer_full(io_buffer_full),
        .if_start_signal(if_start_signal), .if_query_pc(if_query_pc),
        .if_finish_signal(if_finish_signal), .if_inst(if_inst),
        .lsb_start_signal(lsb_start_signal), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr),
        .lsb_size(lsb_size), .lsb_wdata(lsb_wdata),
        .lsb_finish_signal(lsb_finish_signal), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    // Bench RAM behind the port (one-cycle read latency) and its reference image.
    logic [7:0] ram [0:255];
    logic [7:0] mdl [0:255];
    logic       pl_en = 1'b0;
    logic [7:0] pl_a, pl_d;
    always @(posedge clk) begin
        mem_din <= ram[mem_a[7:0]];
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_wr) ram[mem_a[7:0]] <= mem_dout;
    end

    int    n_checks = 0, n_errors = 0;
    string cur = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", cur, tag, got, exp);
        end
    endtask

    // Per-cycle log of one scenario and the model's expectation for it.
    logic [31:0] l_a [0:31];
    logic        l_wr [0:31];
    logic [7:0]  l_do [0:31];
    logic        l_iff [0:31];
    logic        l_lf [0:31];
    logic [31:0] l_inst [0:31];
    logic [31:0] l_rd [0:31];

    logic        e_av [0:31];
    logic [31:0] e_a [0:31];
    logic        e_wr [0:31];
    logic [7:0]  e_do [0:31];
    int          e_iff_cyc, e_lf_cyc, e_nwr;
    logic [31:0] e_inst, e_rd;

    int          rb_cyc, if2_cyc, full_until, hold_from, hold_len;
    logic [31:0] if2_pc;

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d; mdl[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic clear_exp();
        for (int c = 0; c < 32; c++) begin
            e_av[c] = 1'b0; e_a[c] = '0; e_wr[c] = 1'b0; e_do[c] = '0;
        end
        e_iff_cyc = -1; e_lf_cyc = -1; e_nwr = 0; e_inst = '0; e_rd = '0;
        rb_cyc = -1; if2_cyc = -1; if2_pc = '0; full_until = 0;
        hold_from = 1000; hold_len = 0;
    endtask

    // Cycles during which rdy is low simply stretch the access timeline.
    function automatic int rmap(input int c);
        return (c >= hold_from) ? c + hold_len : c;
    endfunction

    function automatic int size_n(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // Model one access: n bytes starting at logical cycle 'start', 'issued'
    // of which reach the bus; reads finish one cycle later than writes.
    task automatic expect_op(input logic is_if, input logic wr, input int start,
                             input logic [31:0] addr, input int n, input logic [31:0] wdata,
                             input int issued, input logic fin, output int fin_cyc);
        logic [31:0] d, a, sh;
        int r;
        d = '0;
        for (int k = 0; k < issued; k++) begin
            r  = rmap(start + k);
            a  = addr + k;
            sh = wdata >> (8 * k);
            e_av[r] = 1'b1; e_a[r] = a; e_wr[r] = wr;
            e_do[r] = wr ? sh[7:0] : 8'h00;
            if (wr) begin
                e_nwr++;
                mdl[a[7:0]] = sh[7:0];
            end else begin
                d = d | ({24'h0, mdl[a[7:0]]} << (8 * k));
            end
        end
        fin_cyc = -1;
        if (fin) begin
            fin_cyc = rmap(start + n + (wr ? 0 : 1));
            if (is_if) begin e_iff_cyc = fin_cyc; e_inst = d; end
            else       begin e_lf_cyc  = fin_cyc; e_rd   = d; end
        end
    endtask

    task automatic apply_ctrl(input int c);
        rollback       = (c == rb_cyc);
        io_buffer_full = (c < full_until);
        rdy            = !(c >= hold_from && c < hold_from + hold_len);
    endtask

    // Called just after a clock edge; that cycle is cycle 0 of the scenario.
    task automatic go(input logic ifp, input logic [31:0] pc, input logic lsp, input logic wr,
                      input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                      input int ncyc);
        if_start_signal = ifp; if_query_pc = pc;
        lsb_start_signal = lsp; lsb_wr = wr; lsb_addr = addr; lsb_size = size; lsb_wdata = wd;
        apply_ctrl(0);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            l_a[c] = mem_a; l_wr[c] = mem_wr; l_do[c] = mem_dout;
            l_iff[c] = if_finish_signal; l_lf[c] = lsb_finish_signal;
            l_inst[c] = if_inst; l_rd[c] = lsb_rdata;
            @(posedge clk); #1;
            lsb_start_signal = 1'b0;
            if_start_signal  = (c + 1 == if2_cyc);
            if (c + 1 == if2_cyc) if_query_pc = if2_pc;
            apply_ctrl(c + 1);
        end
        rollback = 1'b0; io_buffer_full = 1'b0; rdy = 1'b1;
    endtask

    task automatic evaluate(input int ncyc);
        int nwr, nif, nl, fif, fl;
        nwr = 0; nif = 0; nl = 0; fif = -1; fl = -1;
        for (int c = 0; c < ncyc; c++) begin
            if (l_wr[c]) nwr++;
            if (l_iff[c]) begin nif++; if (fif < 0) fif = c; end
            if (l_lf[c])  begin nl++;  if (fl < 0)  fl = c;  end
            if (e_av[c]) begin
                check($sformatf("mem_a@%0d", c), l_a[c], e_a[c]);
                check($sformatf("mem_wr@%0d", c), 32'(l_wr[c]), 32'(e_wr[c]));
                if (e_wr[c]) check($sformatf("mem_dout@%0d", c), 32'(l_do[c]), 32'(e_do[c]));
            end
        end
        check("write_count", 32'(nwr), 32'(e_nwr));
        check("if_finish_count", 32'(nif), (e_iff_cyc >= 0) ? 32'd1 : 32'd0);
        check("lsb_finish_count", 32'(nl), (e_lf_cyc >= 0) ? 32'd1 : 32'd0);
        if (e_iff_cyc >= 0) begin
            check("if_finish_cycle", 32'(fif), 32'(e_iff_cyc));
            check("if_inst", l_inst[e_iff_cyc], e_inst);
            check("if_inst_hold", l_inst[ncyc-1], e_inst);
        end
        if (e_lf_cyc >= 0) begin
            check("lsb_finish_cycle", 32'(fl), 32'(e_lf_cyc));
            if (e_av[1] && !e_wr[1]) check("lsb_rdata", l_rd[e_lf_cyc], e_rd);
        end
    endtask

    initial begin
        int f, st, mode, diff, sn;
        logic do_if, do_ls, wr;
        logic [1:0] size;
        logic [31:0] addr, wd, pc;

        rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
        if_start_signal = 1'b0; if_query_pc = '0;
        lsb_start_signal = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));

        cur = "reset";
        @(negedge clk);
        check("if_finish", 32'(if_finish_signal), 32'd0);
        check("lsb_finish", 32'(lsb_finish_signal), 32'd0);
        check("mem_wr", 32'(mem_wr), 32'd0);
        check("mem_a", mem_a, 32'd0);
        check("mem_dout", 32'(mem_dout), 32'd0);
        check("if_inst", if_inst, 32'd0);
        check("lsb_rdata", lsb_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        cur = "if_word";
        poke(8'h04, 8'h13); poke(8'h05, 8'h05); poke(8'h06, 8'hA0); poke(8'h07, 8'h00);
        clear_exp();
        expect_op(1'b1, 1'b0, 1, 32'h4, 4, 32'h0, 4, 1'b1, f);
        go(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 12);
        evaluate(12);
        check("tp_if_inst", l_inst[6], 32'h00A00513);

        cur = "store_half";
        clear_exp();
        expect_op(1'b0, 1'b1, 1, 32'h100, 2, 32'h1234, 2, 1'b1, f);
        go(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 2'd1, 32'h1234, 8);
        evaluate(8);

        cur = "if_and_byte_load";
        poke(8'h00, 8'hFF);
        clear_exp();
        expect_op(1'b0, 1'b0, 1, 32'h200, 1, 32'h0, 1, 1'b1, f);
        expect_op(1'b1, 1'b0, f + 1, 32'h10, 4, 32'h0, 4, 1'b1, f);
        go(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 2'd0, 32'h0, 14);
        evaluate(14);
        check("tp_lsb_rdata", l_rd[3], 32'h000000FF);

        cur = "rollback_if";
        clear_exp();
        rb_cyc = 3; if2_cyc = 4; if2_pc = 32'h24;
        expect_op(1'b1, 1'b0, 1, 32'h20, 4, 32'h0, 3, 1'b0, f);
        expect_op(1'b1, 1'b0, 5, 32'h24, 4, 32'h0, 4, 1'b1, f);
        go(1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0, 14);
        evaluate(14);

        cur = "rollback_store";
        clear_exp();
        rb_cyc = 2;
        expect_op(1'b0, 1'b1, 1, 32'h40, 4, 32'hCAFEBABE, 4, 1'b1, f);
        go(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 2'd2, 32'hCAFEBABE, 10);
        evaluate(10);

        cur = "rollback_drops_pulse";
        clear_exp();
        rb_cyc = 0;
        go(1'b1, 32'h30, 1'b1, 1'b0, 32'h34, 2'd2, 32'h0, 8);
        evaluate(8);

        cur = "io_store";
        clear_exp();
        full_until = 5;
`ifdef MEM_CTRL_IO_STALL_EN
        st = 6;
`else
        st = 1;
`endif
        expect_op(1'b0, 1'b1, st, 32'h30000, 1, 32'h5A, 1, 1'b1, f);
        expect_op(1'b1, 1'b0, f + 1, 32'h50, 4, 32'h0, 4, 1'b1, f);
        go(1'b1, 32'h50, 1'b1, 1'b1, 32'h30000, 2'd0, 32'h5A, 16);
        evaluate(16);

        cur = "rdy_hold_store";
        clear_exp();
        hold_from = 2; hold_len = 2;
        expect_op(1'b0, 1'b1, 1, 32'h60, 4, 32'h89ABCDEF, 4, 1'b1, f);
        go(1'b0, 32'h0, 1'b1, 1'b1, 32'h60, 2'd2, 32'h89ABCDEF, 10);
        evaluate(10);

        for (int it = 0; it < 40; it++) begin
            cur = $sformatf("rand%0d", it);
            mode = $urandom_range(0, 2);
            do_if = (mode != 1);
            do_ls = (mode != 0);
            wr    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 2));
            addr  = $urandom; wd = $urandom; pc = $urandom;
            sn    = size_n(size);
            clear_exp();
            f = 0;
            if (do_ls) expect_op(1'b0, wr, 1, addr, sn, wd, sn, 1'b1, f);
            if (do_if) expect_op(1'b1, 1'b0, do_ls ? f + 1 : 1, pc, 4, 32'h0, 4, 1'b1, f);
            go(do_if, pc, do_ls, wr, addr, size, wd, 16);
            evaluate(16);
        end

        cur = "final";
        diff = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== mdl[i]) diff++;
        check("ram_image", 32'(diff), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
